// File: rtl/sample_capture_buffer.sv
// sample_capture_buffer
//    Frame capture buffer sitting behind the sampling control stage. After the
//    one-shot power-up Ready pulse has been seen, an Arm request starts a frame:
//    each Enable strobe stores one Sample_in word until 2**ADDR_W samples are
//    held. A change of Mode while filling restarts the frame from address 0.
//    A full frame is drained through a Rd_Req / Rd_Valid handshake with one
//    cycle of read latency; after the last word the block returns to idle.
//
// Ports
//    Fg_CLK      system clock, rising edge
//    RESET       asynchronous, active-high reset
//    Ready       one-cycle power-up pulse; capture is locked out until seen
//    Enable      one-cycle sample strobe
//    Mode        decimation mode; any change mid-fill restarts the frame
//    Sample_in   sample stored on Enable
//    Arm         one-cycle request to start a frame capture
//    Rd_Req      one-cycle request for the next stored sample
//    Rd_Data     sample read out, holds when Rd_Valid is low
//    Rd_Valid    one-cycle pulse qualifying Rd_Data
//    Rd_Last     marks the final sample of the frame (with Rd_Valid)
//    Busy        frame is filling
//    Full        frame complete and awaiting readout
//    Overrun     sticky flag: a sample strobe arrived while a frame was held
//    Fill_Count  samples written to the current frame (0..DEPTH)

module sample_capture_buffer #(
   parameter int DATA_W = 12,
   parameter int ADDR_W = 8
) (
   input  logic              Fg_CLK,
   input  logic              RESET,
   input  logic              Ready,
   input  logic              Enable,
   input  logic [3:0]        Mode,
   input  logic [DATA_W-1:0] Sample_in,
   input  logic              Arm,
   input  logic              Rd_Req,
   output logic [DATA_W-1:0] Rd_Data,
   output logic              Rd_Valid,
   output logic              Rd_Last,
   output logic              Busy,
   output logic              Full,
   output logic              Overrun,
   output logic [ADDR_W:0]   Fill_Count
);

   localparam int DEPTH = 2 ** ADDR_W;
   localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

   typedef enum logic [1:0] {
      IDLE,
      FILL,
      DONE
   } state_t;

   state_t state, state_next;

   logic              rdy_seen;
   logic [3:0]        mode_q;
   logic              mode_chg;
   logic [ADDR_W-1:0] wr_ptr;
   logic [ADDR_W-1:0] rd_ptr;
   logic [DATA_W-1:0] mem [DEPTH];

   logic start;
   logic wr_fire;
   logic rd_fire;
   logic restart;
   logic drop;

   // Mode is sampled every cycle, including during reset, so mode_q already
   // equals Mode when reset releases and no false restart is seen.
   always_ff @(posedge Fg_CLK) begin
      mode_q <= Mode;
   end

   assign mode_chg = (Mode != mode_q);

   // State register.
   always_ff @(posedge Fg_CLK or posedge RESET) begin
      if (RESET) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Next-state logic and the per-cycle action strobes the datapath acts on.
   // A Mode change outranks a coincident Enable, so that sample is discarded.
   always_comb begin
      state_next = state;
      start      = 1'b0;
      wr_fire    = 1'b0;
      rd_fire    = 1'b0;
      restart    = 1'b0;
      drop       = 1'b0;
      case (state)
         IDLE: begin
            if (Arm && rdy_seen) begin
               start      = 1'b1;
               state_next = FILL;
            end
         end
         FILL: begin
            if (mode_chg) begin
               restart = 1'b1;
            end else if (Enable) begin
               wr_fire = 1'b1;
               if (wr_ptr == LAST_ADDR) begin
                  state_next = DONE;
               end
            end
         end
         DONE: begin
            drop = Enable;
            if (Rd_Req) begin
               rd_fire = 1'b1;
               if (rd_ptr == LAST_ADDR) begin
                  state_next = IDLE;
               end
            end
         end
         default: state_next = IDLE;
      endcase
   end

   assign Busy = (state == FILL);
   assign Full = (state == DONE);

   // Ready is remembered until reset; because it is registered, an Arm in the
   // same cycle as the Ready pulse still finds it clear and is ignored.
   always_ff @(posedge Fg_CLK or posedge RESET) begin
      if (RESET) begin
         rdy_seen <= 1'b0;
      end else if (Ready) begin
         rdy_seen <= 1'b1;
      end
   end

   // Write pointer and fill count. The pointer wraps to 0 on the final write,
   // and the count is one bit wider so it can show a complete frame. The
   // count clears when the last word of the frame has been read.
   always_ff @(posedge Fg_CLK or posedge RESET) begin
      if (RESET) begin
         wr_ptr     <= '0;
         Fill_Count <= '0;
      end else if (start || restart) begin
         wr_ptr     <= '0;
         Fill_Count <= '0;
      end else if (wr_fire) begin
         wr_ptr     <= wr_ptr + 1'b1;
         Fill_Count <= Fill_Count + 1'b1;
      end else if (rd_fire && rd_ptr == LAST_ADDR) begin
         Fill_Count <= '0;
      end
   end

   // Overrun flags strobes lost while a frame is held; only a new capture
   // (or reset) clears it.
   always_ff @(posedge Fg_CLK or posedge RESET) begin
      if (RESET) begin
         Overrun <= 1'b0;
      end else if (start) begin
         Overrun <= 1'b0;
      end else if (drop) begin
         Overrun <= 1'b1;
      end
   end

   // Frame storage write port; left unreset so it maps onto block RAM.
   always_ff @(posedge Fg_CLK) begin
      if (wr_fire) begin
         mem[wr_ptr] <= Sample_in;
      end
   end

   // Registered read port and handshake. The read pointer rewinds on the
   // final write so readout always starts at address 0. Rd_Data only loads
   // on a request, so it holds between valid pulses.
   always_ff @(posedge Fg_CLK or posedge RESET) begin
      if (RESET) begin
         rd_ptr   <= '0;
         Rd_Data  <= '0;
         Rd_Valid <= 1'b0;
         Rd_Last  <= 1'b0;
      end else begin
         Rd_Valid <= rd_fire;
         Rd_Last  <= rd_fire && (rd_ptr == LAST_ADDR);
         if (wr_fire && wr_ptr == LAST_ADDR) begin
            rd_ptr <= '0;
         end else if (rd_fire) begin
            rd_ptr  <= rd_ptr + 1'b1;
            Rd_Data <= mem[rd_ptr];
         end
      end
   end

endmodule

// File: tb/tb_sample_capture_buffer.sv
// tb_sample_capture_buffer
//    Directed bench for sample_capture_buffer built with an 8-deep frame.
//    Inputs are driven just after each rising edge and outputs are checked
//    one time unit after the following rising edge.

module tb_sample_capture_buffer;

   localparam int DATA_W = 12;
   localparam int ADDR_W = 3;
   localparam int DEPTH  = 2 ** ADDR_W;

   logic              clock;
   logic              reset;
   logic              ready;
   logic              enable;
   logic [3:0]        mode;
   logic [DATA_W-1:0] sample_in;
   logic              arm;
   logic              rd_req;
   logic [DATA_W-1:0] rd_data;
   logic              rd_valid;
   logic              rd_last;
   logic              busy;
   logic              full;
   logic              overrun;
   logic [ADDR_W:0]   fill_count;

   int checkCount = 0;
   int passCount  = 0;

   sample_capture_buffer #(
      .DATA_W(DATA_W),
      .ADDR_W(ADDR_W)
   ) dut (
      .Fg_CLK    (clock),
      .RESET     (reset),
      .Ready     (ready),
      .Enable    (enable),
      .Mode      (mode),
      .Sample_in (sample_in),
      .Arm       (arm),
      .Rd_Req    (rd_req),
      .Rd_Data   (rd_data),
      .Rd_Valid  (rd_valid),
      .Rd_Last   (rd_last),
      .Busy      (busy),
      .Full      (full),
      .Overrun   (overrun),
      .Fill_Count(fill_count)
   );

   // Free-running 10-unit clock.
   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   // Single comparison point: counts every check and reports any mismatch.
   task automatic checkOutput(input string tag, input logic [31:0] actual,
                              input logic [31:0] expected);
      checkCount++;
      if (actual === expected) begin
         passCount++;
      end else begin
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
      end
   endtask

   // Drive one cycle of inputs, then move to just past the next rising edge.
   task automatic applyStimulus(input logic rdy, input logic armIn, input logic en,
                                input logic [DATA_W-1:0] smp, input logic req);
      ready     = rdy;
      arm       = armIn;
      enable    = en;
      sample_in = smp;
      rd_req    = req;
      @(posedge clock);
      #1;
   endtask

   task automatic idleCycle();
      applyStimulus(1'b0, 1'b0, 1'b0, '0, 1'b0);
   endtask

   // Fill a whole frame with consecutive values starting at base.
   task automatic fillFrame(input logic [DATA_W-1:0] base);
      for (int i = 0; i < DEPTH; i++) begin
         applyStimulus(1'b0, 1'b0, 1'b1, base + DATA_W'(i), 1'b0);
      end
      idleCycle();
   endtask

   // Issue back-to-back requests for the whole frame and check each word.
   task automatic readFrame(input string tag, input logic [DATA_W-1:0] base);
      for (int i = 0; i < DEPTH; i++) begin
         applyStimulus(1'b0, 1'b0, 1'b0, '0, 1'b1);
         checkOutput({tag, "_valid"}, 32'(rd_valid), 32'd1);
         checkOutput({tag, "_data"}, 32'(rd_data), 32'(base + DATA_W'(i)));
         checkOutput({tag, "_last"}, 32'(rd_last), (i == DEPTH - 1) ? 32'd1 : 32'd0);
      end
      checkOutput({tag, "_full_end"}, 32'(full), 32'd0);
      checkOutput({tag, "_busy_end"}, 32'(busy), 32'd0);
      checkOutput({tag, "_count_end"}, 32'(fill_count), 32'd0);
      idleCycle();
      checkOutput({tag, "_valid_off"}, 32'(rd_valid), 32'd0);
      checkOutput({tag, "_last_off"}, 32'(rd_last), 32'd0);
      checkOutput({tag, "_data_hold"}, 32'(rd_data), 32'(base + DATA_W'(DEPTH - 1)));
   endtask

   initial begin
      reset     = 1'b1;
      ready     = 1'b0;
      enable    = 1'b0;
      mode      = 4'd2;
      sample_in = '0;
      arm       = 1'b0;
      rd_req    = 1'b0;
      repeat (3) @(posedge clock);
      #1;
      reset = 1'b0;

      // Reset state and the Ready gate on Arm.
      checkOutput("rst_busy", 32'(busy), 32'd0);
      checkOutput("rst_full", 32'(full), 32'd0);
      checkOutput("rst_count", 32'(fill_count), 32'd0);
      checkOutput("rst_valid", 32'(rd_valid), 32'd0);
      checkOutput("rst_data", 32'(rd_data), 32'd0);
      applyStimulus(1'b0, 1'b1, 1'b0, '0, 1'b0);
      checkOutput("arm_no_ready", 32'(busy), 32'd0);
      applyStimulus(1'b1, 1'b1, 1'b0, '0, 1'b0);
      checkOutput("arm_with_ready", 32'(busy), 32'd0);
      applyStimulus(1'b0, 1'b1, 1'b0, '0, 1'b0);
      checkOutput("arm_after_ready", 32'(busy), 32'd1);
      checkOutput("arm_count", 32'(fill_count), 32'd0);

      // Full frame capture of 0x10..0x17.
      for (int i = 0; i < DEPTH; i++) begin
         applyStimulus(1'b0, 1'b0, 1'b1, 12'h010 + 12'(i), 1'b0);
         if (i == 2) begin
            checkOutput("fill_count3", 32'(fill_count), 32'd3);
         end
      end
      checkOutput("fill_full", 32'(full), 32'd1);
      checkOutput("fill_busy", 32'(busy), 32'd0);
      checkOutput("fill_count8", 32'(fill_count), 32'd8);
      applyStimulus(1'b0, 1'b1, 1'b0, '0, 1'b0);
      checkOutput("done_arm_ignored", 32'(full), 32'd1);
      readFrame("rd1", 12'h010);

      // Mode change coincident with Enable restarts the frame.
      applyStimulus(1'b0, 1'b1, 1'b0, '0, 1'b0);
      checkOutput("arm2_busy", 32'(busy), 32'd1);
      for (int i = 0; i < 5; i++) begin
         applyStimulus(1'b0, 1'b0, 1'b1, 12'h020 + 12'(i), 1'b0);
      end
      checkOutput("pre_chg_count", 32'(fill_count), 32'd5);
      mode = 4'd3;
      applyStimulus(1'b0, 1'b0, 1'b1, 12'h099, 1'b0);
      checkOutput("chg_count", 32'(fill_count), 32'd0);
      checkOutput("chg_busy", 32'(busy), 32'd1);
      fillFrame(12'h030);
      checkOutput("refill_full", 32'(full), 32'd1);
      checkOutput("refill_count", 32'(fill_count), 32'd8);

      // Enables while holding a frame set Overrun and do not disturb it.
      checkOutput("ovr_clear", 32'(overrun), 32'd0);
      applyStimulus(1'b0, 1'b0, 1'b1, 12'hAAA, 1'b0);
      idleCycle();
      applyStimulus(1'b0, 1'b0, 1'b1, 12'hBBB, 1'b0);
      checkOutput("ovr_set", 32'(overrun), 32'd1);
      checkOutput("ovr_full", 32'(full), 32'd1);
      mode = 4'd4;
      idleCycle();
      checkOutput("done_mode_ignored", 32'(fill_count), 32'd8);
      readFrame("rd2", 12'h030);
      checkOutput("ovr_sticky", 32'(overrun), 32'd1);
      applyStimulus(1'b0, 1'b1, 1'b0, '0, 1'b0);
      checkOutput("ovr_cleared_by_arm", 32'(overrun), 32'd0);
      checkOutput("arm3_busy", 32'(busy), 32'd1);

      // Reset in the middle of a readout.
      fillFrame(12'h040);
      for (int i = 0; i < 3; i++) begin
         applyStimulus(1'b0, 1'b0, 1'b0, '0, 1'b1);
         checkOutput("rd3_data", 32'(rd_data), 32'(12'h040 + 12'(i)));
      end
      rd_req = 1'b0;
      reset  = 1'b1;
      #1;
      checkOutput("mid_rst_data", 32'(rd_data), 32'd0);
      checkOutput("mid_rst_valid", 32'(rd_valid), 32'd0);
      checkOutput("mid_rst_full", 32'(full), 32'd0);
      checkOutput("mid_rst_busy", 32'(busy), 32'd0);
      checkOutput("mid_rst_count", 32'(fill_count), 32'd0);
      checkOutput("mid_rst_ovr", 32'(overrun), 32'd0);
      @(posedge clock);
      #1;
      reset = 1'b0;
      applyStimulus(1'b0, 1'b1, 1'b0, '0, 1'b0);
      checkOutput("post_rst_arm", 32'(busy), 32'd0);
      idleCycle();
      checkOutput("post_rst_idle", 32'(busy), 32'd0);

      $display("%0d/%0d checks passed", passCount, checkCount);
      $finish;
   end

endmodule
